// File: rtl/soc_system_sprite_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : soc_system_sprite_reader_pkg
// Description : Shared widths and FSM state encoding for the sprite reader.
// Revision    : 1.0 - initial release
// ============================================================================
package soc_system_sprite_reader_pkg;

    localparam int DEFAULT_ADDR_W     = 11;
    localparam int DEFAULT_DATA_W     = 8;
    localparam int DEFAULT_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage
`default_nettype wire

// File: rtl/sprite_reader_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sprite_reader_fifo
// Description : Small first-word-fall-through FIFO buffering ROM return data.
//               The head is forced to zero while empty so a flushed FIFO
//               never exposes stale bytes.
// Revision    : 1.0 - initial release
// ============================================================================
module sprite_reader_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic [CNT_W-1:0]  count_o,
    output logic [DATA_W-1:0] head_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              do_pop;

    assign do_pop = pop_i && (count_q != '0);

    // Storage array; contents are only visible through a non-zero count
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // Pointers and occupancy; simultaneous push and pop leave count unchanged
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push_i, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign count_o = count_q;
    assign head_o  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;

endmodule
`default_nettype wire

// File: rtl/soc_system_sprite_reader.sv
`default_nettype none
// ============================================================================
// Module      : soc_system_sprite_reader
// Description : Streams a programmed run of bytes from a one-cycle-latency
//               sprite ROM into a valid/ready pixel stream. Reads are only
//               issued when the FIFO has room for the returning byte, so the
//               return path never needs back-pressure.
// Revision    : 1.0 - initial release
// ============================================================================
module soc_system_sprite_reader
    import soc_system_sprite_reader_pkg::*;
#(
    parameter int ADDR_W     = DEFAULT_ADDR_W,
    parameter int DATA_W     = DEFAULT_DATA_W,
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   count,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_chipselect,
    output logic              mem_clken,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_readdata,
    output logic [DATA_W-1:0] px_data,
    output logic              px_valid,
    input  logic              px_ready,
    output logic              px_last
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [ADDR_W:0]   remaining_q, remaining_d;
    logic [ADDR_W:0]   pop_left_q, pop_left_d;
    logic              inflight_q, inflight_d;

    logic              accept;
    logic              issue;
    logic              pop;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W:0]    occupancy;

    // Bytes already buffered plus the one possibly still on its way back
    assign occupancy = (CNT_W+1)'(fifo_count) + (CNT_W+1)'(inflight_q);
    assign accept    = (state_q == IDLE) && start;
    assign issue     = (state_q == FETCH) && (remaining_q != '0)
                       && (occupancy < (CNT_W+1)'(FIFO_DEPTH));
    assign px_valid  = (fifo_count != '0);
    assign pop       = px_valid && px_ready;
    assign px_last   = px_valid && (pop_left_q == (ADDR_W+1)'(1));

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (count == '0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                if (issue && (remaining_q == (ADDR_W+1)'(1))) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && px_last) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Status and bus strobe outputs
    always_comb begin
        busy           = (state_q == FETCH) || (state_q == DRAIN);
        done           = (state_q == DONE);
        mem_chipselect = issue;
        mem_address    = rd_addr_q;
        mem_clken      = 1'b1;
        mem_write      = 1'b0;
    end

    // Address / byte counters: loaded on accepted start, stepped per read and per pop
    always_comb begin
        rd_addr_d   = rd_addr_q;
        remaining_d = remaining_q;
        pop_left_d  = pop_left_q;
        inflight_d  = issue;
        if (accept) begin
            rd_addr_d   = base_addr;
            remaining_d = count;
            pop_left_d  = count;
        end else begin
            if (issue) begin
                rd_addr_d   = rd_addr_q + ADDR_W'(1);
                remaining_d = remaining_q - (ADDR_W+1)'(1);
            end
            if (pop) begin
                pop_left_d = pop_left_q - (ADDR_W+1)'(1);
            end
        end
    end

    // Counter registers; clearing inflight drops any read returning after reset
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_addr_q   <= '0;
            remaining_q <= '0;
            pop_left_q  <= '0;
            inflight_q  <= 1'b0;
        end else begin
            rd_addr_q   <= rd_addr_d;
            remaining_q <= remaining_d;
            pop_left_q  <= pop_left_d;
            inflight_q  <= inflight_d;
        end
    end

    sprite_reader_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (inflight_q),
        .push_data_i (mem_readdata),
        .pop_i       (pop),
        .count_o     (fifo_count),
        .head_o      (px_data)
    );

endmodule
`default_nettype wire

// File: tb/tb_soc_system_sprite_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_soc_system_sprite_reader
// Description : Directed bench with a behavioural ROM (ROM[i] = i & 0xFF)
//               and a negedge monitor logging reads and pixel handshakes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_soc_system_sprite_reader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [10:0] base_addr = '0;
    logic [11:0] count = '0;
    logic        busy, done;
    logic [10:0] mem_address;
    logic        mem_chipselect, mem_clken, mem_write;
    logic [7:0]  mem_readdata = '0;
    logic [7:0]  px_data;
    logic        px_valid, px_last;
    logic        px_ready = 1'b1;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int t0 = 0;
    int rel;

    logic [10:0] addr_q[$];
    int          acyc_q[$];
    logic [7:0]  pix_q[$];
    logic        last_q[$];
    int          pcyc_q[$];
    logic        busy_seen, cs_seen, pv_seen;

    soc_system_sprite_reader dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .base_addr      (base_addr),
        .count          (count),
        .busy           (busy),
        .done           (done),
        .mem_address    (mem_address),
        .mem_chipselect (mem_chipselect),
        .mem_clken      (mem_clken),
        .mem_write      (mem_write),
        .mem_readdata   (mem_readdata),
        .px_data        (px_data),
        .px_valid       (px_valid),
        .px_ready       (px_ready),
        .px_last        (px_last)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ROM model: one-cycle read latency
    always @(posedge clk) begin
        if (mem_chipselect) mem_readdata <= mem_address[7:0];
    end

    // Activity monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (!reset) begin
            if (mem_chipselect) begin
                addr_q.push_back(mem_address);
                acyc_q.push_back(cyc);
            end
            if (px_valid && px_ready) begin
                pix_q.push_back(px_data);
                last_q.push_back(px_last);
                pcyc_q.push_back(cyc);
            end
            if (busy) busy_seen = 1'b1;
            if (mem_chipselect) cs_seen = 1'b1;
            if (px_valid) pv_seen = 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        addr_q.delete(); acyc_q.delete();
        pix_q.delete(); last_q.delete(); pcyc_q.delete();
        busy_seen = 1'b0; cs_seen = 1'b0; pv_seen = 1'b0;
    endtask

    // Start pulse in cycle 0; returns in cycle 1
    task automatic go(input logic [10:0] b, input logic [11:0] n);
        clear_logs();
        base_addr = b;
        count     = n;
        px_ready  = 1'b1;
        start     = 1'b1;
        t0        = cyc;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int r);
        r = -1;
        for (int i = 0; i < limit; i++) begin
            if (done === 1'b1) begin
                r = cyc - t0;
                break;
            end
            tick();
        end
    endtask

    task automatic check_stream(input string tag, input logic [10:0] b, input int n);
        int ea, ed, el;
        ea = 0; ed = 0; el = 0;
        check({tag, " reads"}, addr_q.size(), n);
        check({tag, " pixels"}, pix_q.size(), n);
        for (int i = 0; i < addr_q.size(); i++)
            if (addr_q[i] !== 11'(b + i)) ea++;
        for (int i = 0; i < pix_q.size(); i++) begin
            if (pix_q[i] !== 8'(b + i)) ed++;
            if (last_q[i] !== (i == n - 1)) el++;
        end
        check({tag, " addr errs"}, ea, 0);
        check({tag, " data errs"}, ed, 0);
        check({tag, " last errs"}, el, 0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " busy"}, busy, 0);
        check({tag, " done"}, done, 0);
        check({tag, " cs"}, mem_chipselect, 0);
        check({tag, " addr"}, mem_address, 0);
        check({tag, " clken"}, mem_clken, 1);
        check({tag, " write"}, mem_write, 0);
        check({tag, " pvalid"}, px_valid, 0);
        check({tag, " plast"}, px_last, 0);
        check({tag, " pdata"}, px_data, 0);
    endtask

    initial begin
        // ---------------- reset state ----------------
        tick(); tick();
        check_reset_values("rst");
        reset = 1'b0;
        tick();

        // ---------------- T1: base 0x010, count 4 ----------------
        go(11'h010, 12'd4);
        check("t1 c1 busy", busy, 1);
        check("t1 c1 cs", mem_chipselect, 1);
        check("t1 c1 addr", mem_address, 11'h010);
        tick();
        check("t1 c2 pvalid", px_valid, 0);
        tick();
        check("t1 c3 pvalid", px_valid, 1);
        check("t1 c3 pdata", px_data, 8'h10);
        wait_done(20, rel);
        check("t1 done cycle", rel, 7);
        check("t1 done busy", busy, 0);
        check("t1 first read cyc", (acyc_q.size() > 0) ? acyc_q[0] - t0 : -1, 1);
        check("t1 last read cyc", (acyc_q.size() > 3) ? acyc_q[3] - t0 : -1, 4);
        check("t1 first pix cyc", (pcyc_q.size() > 0) ? pcyc_q[0] - t0 : -1, 3);
        check("t1 last pix cyc", (pcyc_q.size() > 3) ? pcyc_q[3] - t0 : -1, 6);
        check_stream("t1", 11'h010, 4);
        tick();
        check("t1 done pulse end", done, 0);

        // ---------------- T2: address wrap ----------------
        go(11'h7FE, 12'd4);
        wait_done(20, rel);
        check("t2 done cycle", rel, 7);
        check_stream("t2", 11'h7FE, 4);
        tick();

        // ---------------- T3: back-pressure ----------------
        go(11'h100, 12'd16);
        tick();
        tick();                       // cycle 3
        px_ready = 1'b0;
        check("t3 c3 pvalid", px_valid, 1);
        check("t3 c3 pdata", px_data, 8'h00);
        repeat (9) tick();            // cycle 12
        check("t3 c12 cs", mem_chipselect, 0);
        check("t3 c12 reads", addr_q.size(), 4);
        check("t3 c12 pvalid", px_valid, 1);
        check("t3 c12 pdata", px_data, 8'h00);
        check("t3 c12 pixels", pix_q.size(), 0);
        tick();                       // cycle 13
        px_ready = 1'b1;
        wait_done(100, rel);
        check("t3 done seen", (rel > 0), 1);
        check_stream("t3", 11'h100, 16);
        tick();

        // ---------------- T4: zero count ----------------
        go(11'h123, 12'd0);
        check("t4 c1 done", done, 1);
        check("t4 c1 busy", busy, 0);
        tick();
        check("t4 c2 done", done, 0);
        tick(); tick();
        check("t4 busy seen", busy_seen, 0);
        check("t4 cs seen", cs_seen, 0);
        check("t4 pvalid seen", pv_seen, 0);

        // ---------------- T5: full ROM, stray starts ----------------
        go(11'h000, 12'd2048);
        repeat (99) tick();           // cycle 100
        start = 1'b1; base_addr = 11'h555; count = 12'd7;
        tick();
        start = 1'b0;
        repeat (899) tick();          // cycle 1001
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(2000, rel);
        check("t5 done cycle", rel, 2051);
        start = 1'b1;                 // start during DONE must be ignored
        tick();
        start = 1'b0;
        check("t5 post-done busy", busy, 0);
        check("t5 post-done cs", mem_chipselect, 0);
        tick();
        check("t5 post-done busy2", busy, 0);
        check_stream("t5", 11'h000, 2048);

        // ---------------- T6: mid-transfer reset ----------------
        go(11'h020, 12'd10);
        repeat (4) tick();            // cycle 5
        reset = 1'b1;
        tick();                       // cycle 6
        reset = 1'b0;
        check_reset_values("t6 c6");
        tick();                       // cycle 7: late read must be dropped
        check("t6 c7 pvalid", px_valid, 0);
        check("t6 c7 busy", busy, 0);
        go(11'h040, 12'd3);
        wait_done(20, rel);
        check("t6 rerun done cycle", rel, 6);
        check_stream("t6", 11'h040, 3);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/soc_system_sprite_reader.md
# soc_system_sprite_reader

Bus-initiator block that streams sprite bytes out of a single-port on-chip sprite ROM (2048 x 8, Avalon-MM slave, one-cycle read latency), such as the ending-screen sprite memory. On a start command it issues sequential reads from a base address for a programmed byte count, buffers returned data, and presents it as a valid/ready pixel stream to the VGA sprite renderer. It is the read-side counterpart of the sprite memories in the soc_system tank-game display path.

## Interface
- ADDR_W, 11, memory address width (2048 words)
- DATA_W, 8, memory/pixel data width
- FIFO_DEPTH, 4, return-data buffer entries (power of two, >= 2)
- clk  in  1  system clock; the only clock
- reset  in  1  synchronous, active-high reset
- start  in  1  begin a transfer; sampled only while busy = 0
- base_addr  in  ADDR_W  first ROM address of the transfer
- count  in  ADDR_W+1  number of bytes to read, 0..2048
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse when the transfer completes
- mem_address  out  ADDR_W  ROM address
- mem_chipselect  out  1  read strobe; one read issued per cycle it is high
- mem_clken  out  1  ROM clock enable; constant 1
- mem_write  out  1  constant 0; the block never writes
- mem_readdata  in  DATA_W  ROM data, valid the cycle after the read is issued
- px_data  out  DATA_W  pixel byte (FIFO head)
- px_valid  out  1  px_data valid
- px_ready  in  1  downstream accepts when px_valid & px_ready
- px_last  out  1  high with the final byte of the transfer

## Operation
- States: IDLE, FETCH, DRAIN, DONE.
- IDLE: start = 1 latches base_addr into rd_addr and count into remaining and pop_left. count = 0 -> DONE directly, no reads issued; otherwise -> FETCH.
- FETCH: issue read (mem_chipselect = 1, mem_address = rd_addr) when remaining != 0 and fifo_count + inflight < FIFO_DEPTH. Per issue: rd_addr += 1 modulo 2^ADDR_W (2047 wraps to 0), remaining -= 1. remaining reaches 0 -> DRAIN.
- inflight: 1-bit register, set the cycle a read is issued; the following cycle mem_readdata is pushed into the FIFO unconditionally (credit rule guarantees space).
- Pop: on px_valid & px_ready, FIFO pops, pop_left -= 1. px_last = px_valid & (pop_left == 1).
- DRAIN: no reads; stays until handshake with px_last -> DONE.
- DONE: done = 1, busy = 0 for exactly one cycle -> IDLE. start in the DONE cycle is ignored; start is accepted only in IDLE.
- start while busy = 1: ignored, no effect on the transfer in progress.
- Simultaneous FIFO push and pop: both take effect; fifo_count unchanged.
- px_valid = (fifo_count != 0); px_data is stable while px_valid & ~px_ready.
- reset (any state, including mid-transfer): state -> IDLE, FIFO emptied, inflight cleared; a read returning the cycle after reset is discarded.

## Timing
- Reset values: busy 0, done 0, mem_chipselect 0, mem_address 0, mem_clken 1, mem_write 0, px_valid 0, px_last 0, px_data 0.
- busy = 1 in every cycle of FETCH and DRAIN.
- start high in cycle 0 (IDLE) -> cycle 1: mem_chipselect = 1, mem_address = base_addr, busy = 1; cycle 2: data pushed; cycle 3: px_valid = 1.
- With px_ready held high: one read and one pixel per cycle sustained; N-byte transfer has last handshake in cycle N+2, done in cycle N+3.
- count = 0: done in cycle 1, busy never asserted, no mem_chipselect.
- Outputs are registered except px_valid/px_data/px_last (from FIFO state registers, no combinational path from px_ready).

## Structure
- Package soc_system_sprite_reader_pkg: ADDR_W, DATA_W defaults and the state enum (IDLE, FETCH, DRAIN, DONE).
- Sub-module sprite_reader_fifo: synchronous FIFO_DEPTH x DATA_W, push/pop/count/head, first-word-fall-through; top holds FSM, address/count counters, inflight, credit check.

## Test plan
- base_addr = 0x010, count = 4, px_ready = 1, ROM[i] = i & 0xFF -> reads at 0x010..0x013 cycles 1-4, px_data 0x10..0x13 cycles 3-6, px_last with 0x13, done cycle 7.
- base_addr = 0x7FE, count = 4 -> addresses 0x7FE, 0x7FF, 0x000, 0x001; pixels 0xFE, 0xFF, 0x00, 0x01.
- count = 16, px_ready low for cycles 3-12 -> mem_chipselect stops once fifo_count + inflight = 4, no byte lost or duplicated, px_data held stable, all 16 bytes in order after release.
- count = 0 -> done pulse in cycle 1, busy and mem_chipselect never high, px_valid never high.
- count = 2048, base_addr = 0 -> every address read exactly once, px_last only on the 2048th byte; start pulses mid-transfer ignored.
- reset asserted in cycle 5 of a count = 10 transfer -> next cycle all outputs at reset values, FIFO empty; a new start afterward runs a clean transfer.
